// File: rtl/harm_note_pkg.sv
// rtl/harm_note_pkg.sv - shared widths, envelope states and quarter-wave sine lookup for harm_note
package harm_note_pkg;

    localparam int SINE_QUANT = 5;
    localparam int PCM_QUANT  = 8;
    localparam logic [3:0] HARM_MUTE = 4'hF;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    // 32-point sine, amplitude 127, built from a 9-entry quarter wave by mirroring.
    function automatic logic signed [PCM_QUANT-1:0] sin_lut(input logic [SINE_QUANT-1:0] idx);
        logic [3:0]                  a;
        logic [PCM_QUANT-1:0]        mag;
        logic signed [PCM_QUANT-1:0] s_mag;
        a = idx[3] ? (4'd8 - {1'b0, idx[2:0]}) : {1'b0, idx[2:0]};
        case (a)
            4'd0:    mag = 8'd0;
            4'd1:    mag = 8'd25;
            4'd2:    mag = 8'd49;
            4'd3:    mag = 8'd71;
            4'd4:    mag = 8'd90;
            4'd5:    mag = 8'd106;
            4'd6:    mag = 8'd117;
            4'd7:    mag = 8'd125;
            4'd8:    mag = 8'd127;
            default: mag = 8'd0;
        endcase
        s_mag = $signed(mag);
        return idx[4] ? -s_mag : s_mag;
    endfunction

endpackage

// File: rtl/harm_note_env.sv
// rtl/harm_note_env.sv - gate-driven attack/sustain/release envelope with tick divider and note-on pulse
module harm_note_env
    import harm_note_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int ENV_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             gate,
    input  logic [DIV_W-1:0] env_div,
    output logic [ENV_W-1:0] level,
    output logic             busy,
    output logic             note_on
);

    localparam logic [ENV_W-1:0] LVL_MAX = '1;

    env_state_t       r_state, w_state_n;
    logic [ENV_W-1:0] r_level, w_level_n;
    logic [DIV_W-1:0] r_envdiv, w_envdiv_n;
    logic             r_busy;
    logic             w_tick;
    logic             w_note_on;

    assign w_tick = (r_envdiv >= env_div);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ENV_IDLE;
            r_level  <= '0;
            r_envdiv <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_level  <= w_level_n;
            r_envdiv <= w_envdiv_n;
            r_busy   <= (r_state != ENV_IDLE);
        end
    end

    // Gate changes take priority over a coincident tick.
    always_comb begin
        w_state_n  = r_state;
        w_level_n  = r_level;
        w_envdiv_n = w_tick ? '0 : r_envdiv + DIV_W'(1);
        w_note_on  = 1'b0;
        unique case (r_state)
            ENV_IDLE: begin
                w_level_n = '0;
                if (gate) begin
                    w_state_n = ENV_ATTACK;
                    w_note_on = 1'b1;
                end
            end
            ENV_ATTACK: begin
                if (!gate) begin
                    w_state_n = ENV_RELEASE;
                end else if (r_level == LVL_MAX) begin
                    w_state_n = ENV_SUSTAIN;
                end else if (w_tick) begin
                    w_level_n = r_level + ENV_W'(1);
                    if (r_level == LVL_MAX - ENV_W'(1))
                        w_state_n = ENV_SUSTAIN;
                end
            end
            ENV_SUSTAIN: begin
                w_level_n = LVL_MAX;
                if (!gate)
                    w_state_n = ENV_RELEASE;
            end
            ENV_RELEASE: begin
                if (gate) begin
                    w_state_n = ENV_ATTACK;
                end else if (r_level == '0) begin
                    w_state_n = ENV_IDLE;
                end else if (w_tick) begin
                    w_level_n = r_level - ENV_W'(1);
                    if (r_level == ENV_W'(1))
                        w_state_n = ENV_IDLE;
                end
            end
        endcase
        if (w_state_n != r_state)
            w_envdiv_n = '0;
    end

    assign level   = r_level;
    assign busy    = r_busy;
    assign note_on = w_note_on;

endmodule

// File: rtl/harm_note.sv
// rtl/harm_note.sv - multi-harmonic note oscillator with envelope; HARM_NOTE_SAT_EN selects saturating mix
module harm_note
    import harm_note_pkg::*;
#(
    parameter int PHASE_W = SINE_QUANT,
    parameter int PCM_W   = PCM_QUANT,
    parameter int DIV_W   = 16,
    parameter int NHARM   = 4,
    parameter int ENV_W   = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    gate,
    input  logic [DIV_W-1:0]        cyc,
    input  logic [DIV_W-1:0]        env_div,
    input  logic [4*NHARM-1:0]      harm_shift,
    output logic signed [PCM_W-1:0] y,
    output logic                    busy
);

    localparam int SLOT_W = (NHARM > 1) ? $clog2(NHARM) : 1;
    localparam int SUM_W  = PCM_W + $clog2(NHARM);

    logic [PHASE_W-1:0]        r_phase;
    logic [DIV_W-1:0]          r_freqdiv;
    logic [SLOT_W-1:0]         r_slot;
    logic signed [PCM_W-1:0]   r_harm_y [NHARM];
    logic signed [PCM_W-1:0]   r_mix;
    logic signed [PCM_W-1:0]   r_y;

    logic [PHASE_W-1:0]        w_mult;
    logic [PHASE_W-1:0]        w_idx;
    logic signed [PCM_W-1:0]   w_sin;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [PCM_W-1:0]   w_mix_n;
    logic signed [PCM_W+ENV_W:0] w_prod;
    logic [ENV_W-1:0]          w_level;
    logic                      w_busy;
    logic                      w_note_on;

    harm_note_env #(
        .DIV_W (DIV_W),
        .ENV_W (ENV_W)
    ) u_env (
        .clk     (clk),
        .clr     (clr),
        .gate    (gate),
        .env_div (env_div),
        .level   (w_level),
        .busy    (w_busy),
        .note_on (w_note_on)
    );

    // One shared sine lookup; slot k reads the table at (k+1) times the phase.
    assign w_mult = PHASE_W'(r_slot) + PHASE_W'(1);
    assign w_idx  = r_phase * w_mult;
    assign w_sin  = PCM_W'(sin_lut(w_idx[PHASE_W-1 -: SINE_QUANT])) <<< (PCM_W - PCM_QUANT);

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NHARM; k++) begin
            if (harm_shift[4*k +: 4] != HARM_MUTE)
                w_sum = w_sum + (SUM_W'(r_harm_y[k]) >>> harm_shift[4*k +: 4]);
        end
    end

`ifdef HARM_NOTE_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (PCM_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

    always_comb begin
        w_mix_n = w_sum[PCM_W-1:0];
        if (w_sum > SAT_MAX)
            w_mix_n = {1'b0, {(PCM_W-1){1'b1}}};
        else if (w_sum < SAT_MIN)
            w_mix_n = {1'b1, {(PCM_W-1){1'b0}}};
    end
`else
    assign w_mix_n = w_sum[PCM_W-1:0];
`endif

    assign w_prod = r_mix * $signed({1'b0, w_level});

    always_ff @(posedge clk) begin
        if (clr) begin
            r_phase   <= '0;
            r_freqdiv <= '0;
            r_slot    <= '0;
            r_mix     <= '0;
            r_y       <= '0;
            for (int k = 0; k < NHARM; k++)
                r_harm_y[k] <= '0;
        end else begin
            if (w_note_on) begin
                r_phase   <= '0;
                r_freqdiv <= '0;
            end else if (r_freqdiv >= cyc) begin
                r_phase   <= r_phase + PHASE_W'(1);
                r_freqdiv <= '0;
            end else begin
                r_freqdiv <= r_freqdiv + DIV_W'(1);
            end
            r_slot           <= (r_slot == SLOT_W'(NHARM - 1)) ? '0 : r_slot + SLOT_W'(1);
            r_harm_y[r_slot] <= w_sin;
            r_mix            <= w_mix_n;
            r_y              <= w_prod[ENV_W +: PCM_W];
        end
    end

    assign y    = r_y;
    assign busy = w_busy;

endmodule

// File: tb/tb_harm_note.sv
// tb/tb_harm_note.sv - randomized self-checking bench for harm_note against a cycle reference model
module tb_harm_note;

    localparam int NH   = 4;
    localparam int NPH  = 32;
    localparam int LMAX = 255;
    localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

    logic              clk = 1'b0;
    logic              clr;
    logic              gate;
    logic [15:0]       cyc;
    logic [15:0]       env_div;
    logic [15:0]       harm_shift;
    logic signed [7:0] y;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    int m_phase, m_fd, m_slot, m_mix, m_level, m_state, m_envdiv, m_y, m_busy;
    int m_h [NH];

    always #5 clk = ~clk;

    harm_note dut (
        .clk        (clk),
        .clr        (clr),
        .gate       (gate),
        .cyc        (cyc),
        .env_div    (env_div),
        .harm_shift (harm_shift),
        .y          (y),
        .busy       (busy)
    );

    function automatic int sine_ref(int i);
        real r;
        r = $sin(2.0 * 3.14159265358979 * i / 32.0) * 127.0;
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    function automatic int reduce_mix(int s);
        int w;
`ifdef HARM_NOTE_SAT_EN
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
`else
        w = ((s % 256) + 256) % 256;
        return (w >= 128) ? w - 256 : w;
`endif
    endfunction

    task automatic model_step();
        int st, lv, ed, non, sum, sh;
        int n_h [NH];
        if (clr) begin
            m_phase = 0; m_fd = 0; m_slot = 0; m_mix = 0; m_level = 0;
            m_state = S_IDLE; m_envdiv = 0; m_y = 0; m_busy = 0;
            for (int k = 0; k < NH; k++) m_h[k] = 0;
            return;
        end
        st  = m_state;
        lv  = m_level;
        ed  = (m_envdiv >= int'(env_div)) ? 0 : (m_envdiv + 1) % 65536;
        non = 0;
        case (m_state)
            S_IDLE: begin lv = 0; if (gate) begin st = S_ATT; non = 1; end end
            S_ATT: begin
                if (!gate) st = S_REL;
                else if (m_level == LMAX) st = S_SUS;
                else if (m_envdiv >= int'(env_div)) begin lv = m_level + 1; if (lv == LMAX) st = S_SUS; end
            end
            S_SUS: begin lv = LMAX; if (!gate) st = S_REL; end
            default: begin
                if (gate) st = S_ATT;
                else if (m_level == 0) st = S_IDLE;
                else if (m_envdiv >= int'(env_div)) begin lv = m_level - 1; if (lv == 0) st = S_IDLE; end
            end
        endcase
        if (st != m_state) ed = 0;

        sum = 0;
        for (int k = 0; k < NH; k++) begin
            sh = (harm_shift >> (4 * k)) & 15;
            if (sh != 15) sum += m_h[k] >>> sh;
        end
        for (int k = 0; k < NH; k++) n_h[k] = m_h[k];
        n_h[m_slot] = sine_ref((m_phase * (m_slot + 1)) % NPH);

        m_y    = (m_mix * m_level) >>> 8;
        m_busy = (m_state != S_IDLE) ? 1 : 0;
        m_mix  = reduce_mix(sum);
        for (int k = 0; k < NH; k++) m_h[k] = n_h[k];
        m_slot = (m_slot + 1) % NH;
        if (non != 0) begin
            m_phase = 0; m_fd = 0;
        end else if (m_fd >= int'(cyc)) begin
            m_phase = (m_phase + 1) % NPH; m_fd = 0;
        end else begin
            m_fd = m_fd + 1;
        end
        m_state = st; m_level = lv; m_envdiv = ed;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; gate = 1'b0;
        tick(); tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; gate = 1'b1; cyc = 16'd3; env_div = 16'd0; harm_shift = 16'hFFF0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (y !== 8'sd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", y); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
            n_cmp++; if (dut.r_phase !== 5'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", dut.r_phase); end
        end
        clr = 1'b0;
        tick();
        n_cmp++; if (int'(busy) !== m_busy) begin n_bad++; $display("FAIL reset_rel_busy0: got %0b want %0d", busy, m_busy); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_rel_busy1: got %0b want 1", busy); end
    endtask

    task automatic test_divider();
        int p, guard;
        do_reset();
        gate = 1'b1; cyc = 16'd3; env_div = 16'd0;
        tick();
        for (int i = 1; i <= 4 * NPH; i++) begin
            tick();
            n_cmp++; if (int'(dut.r_phase) !== m_phase) begin n_bad++; $display("FAIL div_phase: got %0d want %0d", dut.r_phase, m_phase); end
            if (i == 4) begin
                n_cmp++; if (dut.r_phase !== 5'd1) begin n_bad++; $display("FAIL div_step4: got %0d want 1", dut.r_phase); end
            end
        end
        n_cmp++; if (dut.r_phase !== 5'd0) begin n_bad++; $display("FAIL div_wrap: got %0d want 0", dut.r_phase); end
        guard = 0;
        while (m_fd != 2 && guard < 8) begin tick(); guard++; end
        if (m_fd != 2) begin n_cmp++; n_bad++; $display("FAIL div_fd2_timeout: got fd %0d want 2", m_fd); end
        p = m_phase;
        cyc = 16'd1;
        tick();
        n_cmp++; if (int'(dut.r_phase) !== (p + 1) % NPH) begin n_bad++; $display("FAIL div_cyc_drop: got %0d want %0d", dut.r_phase, (p + 1) % NPH); end
        n_cmp++; if (dut.r_freqdiv !== 16'd0) begin n_bad++; $display("FAIL div_fd_clear: got %0d want 0", dut.r_freqdiv); end
    endtask

    task automatic test_harmonics();
        int guard;
        do_reset();
        gate = 1'b1; cyc = 16'd2; env_div = 16'd0; harm_shift = 16'hFFF0;
        guard = 0;
        while (m_state != S_SUS && guard < 400) begin tick(); guard++; end
        if (m_state != S_SUS) begin n_cmp++; n_bad++; $display("FAIL harm_sustain_timeout: state %0d want %0d", m_state, S_SUS); end
        for (int i = 0; i < 200; i++) begin
            tick();
            n_cmp++; if (int'(y) !== m_y) begin n_bad++; $display("FAIL harm_fund_y: got %0d want %0d", y, m_y); end
        end
        harm_shift = 16'hFF0F;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_cmp++; if (int'(y) !== m_y) begin n_bad++; $display("FAIL harm_2x_y: got %0d want %0d", y, m_y); end
        end
    endtask

    task automatic test_envelope();
        do_reset();
        gate = 1'b1; cyc = 16'd1; env_div = 16'd0; harm_shift = 16'hFFF0;
        tick();
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i == 254) begin
                n_cmp++; if (dut.u_env.r_level !== 8'd254) begin n_bad++; $display("FAIL env_att254: got %0d want 254", dut.u_env.r_level); end
            end
        end
        n_cmp++; if (dut.u_env.r_level !== 8'd255) begin n_bad++; $display("FAIL env_att255: got %0d want 255", dut.u_env.r_level); end
        n_cmp++; if (int'(dut.u_env.r_state) !== S_SUS) begin n_bad++; $display("FAIL env_sus: got %0d want %0d", dut.u_env.r_state, S_SUS); end
        gate = 1'b0;
        tick();
        n_cmp++; if (int'(dut.u_env.r_state) !== S_REL) begin n_bad++; $display("FAIL env_rel: got %0d want %0d", dut.u_env.r_state, S_REL); end
        for (int i = 1; i <= 255; i++) begin
            tick();
            n_cmp++; if (int'(y) !== m_y) begin n_bad++; $display("FAIL env_rel_y: got %0d want %0d", y, m_y); end
        end
        n_cmp++; if (dut.u_env.r_level !== 8'd0) begin n_bad++; $display("FAIL env_rel0: got %0d want 0", dut.u_env.r_level); end
        n_cmp++; if (int'(dut.u_env.r_state) !== S_IDLE) begin n_bad++; $display("FAIL env_idle: got %0d want 0", dut.u_env.r_state); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL env_busy_hold: got %0b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL env_busy_drop: got %0b want 0", busy); end
    endtask

    task automatic test_retrigger();
        int guard;
        do_reset();
        gate = 1'b1; cyc = 16'd1; env_div = 16'd0; harm_shift = 16'hFFF0;
        guard = 0;
        while (m_state != S_SUS && guard < 400) begin tick(); guard++; end
        if (m_state != S_SUS) begin n_cmp++; n_bad++; $display("FAIL retrig_sus_timeout: state %0d want %0d", m_state, S_SUS); end
        gate = 1'b0;
        guard = 0;
        while (m_level != 100 && guard < 400) begin tick(); guard++; end
        if (m_level != 100) begin n_cmp++; n_bad++; $display("FAIL retrig_100_timeout: level %0d want 100", m_level); end
        gate = 1'b1;
        tick();
        n_cmp++; if (dut.u_env.r_level !== 8'd100) begin n_bad++; $display("FAIL retrig_level: got %0d want 100", dut.u_env.r_level); end
        n_cmp++; if (int'(dut.u_env.r_state) !== S_ATT) begin n_bad++; $display("FAIL retrig_state: got %0d want %0d", dut.u_env.r_state, S_ATT); end
        n_cmp++; if (int'(dut.r_phase) !== m_phase) begin n_bad++; $display("FAIL retrig_phase: got %0d want %0d", dut.r_phase, m_phase); end
        tick();
        n_cmp++; if (dut.u_env.r_level !== 8'd101) begin n_bad++; $display("FAIL retrig_rise: got %0d want 101", dut.u_env.r_level); end
    endtask

    task automatic test_saturation();
        int guard, want;
`ifdef HARM_NOTE_SAT_EN
        want = 127;
`else
        want = -21;
`endif
        do_reset();
        gate = 1'b1; cyc = 16'd3; env_div = 16'd0; harm_shift = 16'h0000;
        tick();
        guard = 0;
        while (m_phase != 1 && guard < 16) begin tick(); guard++; end
        if (m_phase != 1) begin n_cmp++; n_bad++; $display("FAIL sat_phase_timeout: phase %0d want 1", m_phase); end
        cyc = 16'hFFFF;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (int'($signed(dut.r_mix)) !== want) begin n_bad++; $display("FAIL sat_mix: got %0d want %0d", $signed(dut.r_mix), want); end
        n_cmp++; if (int'($signed(dut.r_mix)) !== m_mix) begin n_bad++; $display("FAIL sat_mix_model: got %0d want %0d", $signed(dut.r_mix), m_mix); end
        tick();
        n_cmp++; if (int'(y) !== m_y) begin n_bad++; $display("FAIL sat_y: got %0d want %0d", y, m_y); end
    endtask

    task automatic test_random();
        logic [3:0] nib;
        do_reset();
        gate = 1'b0; cyc = 16'd2; env_div = 16'd1; harm_shift = 16'hF0F1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            n_cmp++; if (int'(y) !== m_y) begin n_bad++; $display("FAIL rand_y @%0d: got %0d want %0d", i, y, m_y); end
            n_cmp++; if (int'(busy) !== m_busy) begin n_bad++; $display("FAIL rand_busy @%0d: got %0b want %0d", i, busy, m_busy); end
            clr = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            if ($urandom_range(0, 63) == 0) cyc = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 63) == 0) env_div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                for (int k = 0; k < NH; k++) begin
                    nib = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                    harm_shift[4*k +: 4] = nib;
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; gate = 1'b0; cyc = 16'd0; env_div = 16'd0; harm_shift = 16'hFFFF;
        test_reset();
        test_divider();
        test_harmonics();
        test_envelope();
        test_retrigger();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
